uart_core_param: RTL and testbench

- Parametrised successor to the fixed-rate PLL-clocked UART top.
- Full-duplex UART on the system clock with an internal fractional-free baud divider (no PLL).
- Configurable data width, parity mode and stop-bit count.
- Valid/ready TX handshake, 16x-oversampled RX with start-bit validation and error flags.
- Sits between the host-side byte streams and the board-level serial pins.

---
 rtl/uart_core_param.sv | 211 +++++++++++++++++++++
 tb/tb_uart_core_param.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// Full-duplex UART on the system clock: a TX path with valid/ready intake and
// a 16x-oversampled RX path with start-bit validation, parity and framing flags.
//
// Handshake: a word is taken on any rising clk edge where tx_valid && tx_ready.
// tx_ready is high exactly while the transmitter is idle, and tx_data is only
// sampled on that edge. rx_valid is a one-cycle strobe with no back-pressure.
module uart_core_param #(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic [2:0]           tx_state_dbg,
  output logic [2:0]           rx_state_dbg
);
  localparam int BIT_CLKS = 16 * CLK_DIV;
  localparam int CW = $clog2(BIT_CLKS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic ODD = (PARITY == 2);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  // ---------------------------------------------------------------- TX path
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  tx_state_t tx_state, tx_next;

  logic [CW-1:0]        tx_cnt;
  logic [2:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_bit_end;

  assign tx_bit_end   = (tx_cnt == CW'(BIT_CLKS - 1));
  assign tx_ready     = (tx_state == TX_IDLE);
  assign tx_state_dbg = tx_state;

  // TX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next state: leave a bit state only when its bit time has elapsed
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_valid) tx_next = TX_START;
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == LAST_DATA)
                  tx_next = (PARITY != 0) ? TX_PAR : TX_STOP;
      TX_PAR:   if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end && tx_idx == LAST_STOP) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX datapath: per-bit clock timer, bit index and outgoing shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      if (tx_valid) begin
        tx_sh  <= tx_data;
        tx_par <= (^tx_data) ^ ODD;
      end
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      if (tx_state == TX_DATA) begin
        tx_sh  <= tx_sh >> 1;
        tx_idx <= (tx_idx == LAST_DATA) ? 3'd0 : tx_idx + 3'd1;
      end else if (tx_state == TX_STOP) begin
        tx_idx <= tx_idx + 3'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // Line level for the bit currently on the wire
  always_comb begin
    tx_out = 1'b1;
    case (tx_state)
      TX_START: tx_out = 1'b0;
      TX_DATA:  tx_out = tx_sh[0];
      TX_PAR:   tx_out = tx_par;
      default:  tx_out = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP,
                            RX_WAIT_HIGH} rx_state_t;
  rx_state_t rx_state, rx_next;

  logic                 rx_s1, rx_s2, rx_s3;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr;
  logic                 mid_bit;

  assign tick         = (div_cnt == DW'(CLK_DIV - 1));
  assign mid_bit      = tick && (rx_tcnt == 4'd15);
  assign rx_state_dbg = rx_state;

  // Two-flop synchroniser plus one stage of history for falling-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Free-running oversample divider, one-cycle tick every CLK_DIV clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + DW'(1);
  end

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // RX next state: validate start at mid-start, then sample at every mid-bit
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (rx_s3 && !rx_s2) rx_next = RX_START;
      RX_START:     if (tick) begin
                      if (rx_s2)                 rx_next = RX_IDLE;
                      else if (rx_tcnt == 4'd7)  rx_next = RX_DATA;
                    end
      RX_DATA:      if (mid_bit && rx_idx == LAST_DATA)
                      rx_next = (PARITY != 0) ? RX_PAR : RX_STOP;
      RX_PAR:       if (mid_bit) rx_next = RX_STOP;
      RX_STOP:      if (mid_bit) rx_next = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: tick counting, shift-in, parity check and result delivery
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_tcnt       <= '0;
      rx_idx        <= '0;
      rx_sh         <= '0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_tcnt <= '0;
          rx_idx  <= '0;
          rx_perr <= 1'b0;
        end
        RX_START: if (tick) rx_tcnt <= (rx_tcnt == 4'd7) ? 4'd0 : rx_tcnt + 4'd1;
        RX_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (mid_bit) begin
            rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_idx <= rx_idx + 3'd1;
          end
        end
        RX_PAR: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (mid_bit) rx_perr <= rx_s2 ^ (^rx_sh) ^ ODD;
        end
        RX_STOP: if (mid_bit) begin
          // Data is delivered even when a flag is raised
          rx_data       <= rx_sh;
          rx_parity_err <= rx_perr;
          rx_frame_err  <= !rx_s2;
          rx_valid      <= 1'b1;
        end else if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three instances at CLK_DIV=4 (bit = 64 clocks):
// u0 8N1 (TX timing, RX glitch/break), u1 8E1 with tx_out looped to rx_in,
// u2 8O2 with the RX line driven directly by the bench.
module tb_uart_core_param;
  localparam int BITC = 64;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       tx_valid0, tx_ready0, tx_out0, rx_in0, rx_valid0, perr0, ferr0;
  logic [7:0] tx_data0, rx_data0;
  logic [2:0] txs0, rxs0;
  logic       tx_valid1, tx_ready1, tx_out1, rx_valid1, perr1, ferr1;
  logic [7:0] tx_data1, rx_data1;
  logic [2:0] txs1, rxs1;
  logic       tx_valid2, tx_ready2, tx_out2, rx_in2, rx_valid2, perr2, ferr2;
  logic [7:0] tx_data2, rx_data2;
  logic [2:0] txs2, rxs2;

  uart_core_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid0), .tx_data(tx_data0),
    .tx_ready(tx_ready0), .tx_out(tx_out0), .rx_in(rx_in0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .rx_parity_err(perr0), .rx_frame_err(ferr0),
    .tx_state_dbg(txs0), .rx_state_dbg(rxs0));

  uart_core_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid1), .tx_data(tx_data1),
    .tx_ready(tx_ready1), .tx_out(tx_out1), .rx_in(tx_out1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .rx_parity_err(perr1), .rx_frame_err(ferr1),
    .tx_state_dbg(txs1), .rx_state_dbg(rxs1));

  uart_core_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid2), .tx_data(tx_data2),
    .tx_ready(tx_ready2), .tx_out(tx_out2), .rx_in(rx_in2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .rx_parity_err(perr2), .rx_frame_err(ferr2),
    .tx_state_dbg(txs2), .rx_state_dbg(rxs2));

  // ------------------------------------------------------------ scoreboard
  int total = 0;
  int bad = 0;
  logic [9:0] exp_q0[$], exp_q1[$], exp_q2[$];   // {frame_err, parity_err, data}
  logic [9:0] e0, e1, e2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid0) begin
      check("rx0_strobe_expected", 32'(exp_q0.size() != 0), 32'd1);
      if (exp_q0.size() != 0) begin
        e0 = exp_q0.pop_front();
        check("rx0_word", 32'({ferr0, perr0, rx_data0}), 32'(e0));
      end
    end
    if (rx_valid1) begin
      check("rx1_strobe_expected", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) begin
        e1 = exp_q1.pop_front();
        check("rx1_word", 32'({ferr1, perr1, rx_data1}), 32'(e1));
      end
    end
    if (rx_valid2) begin
      check("rx2_strobe_expected", 32'(exp_q2.size() != 0), 32'd1);
      if (exp_q2.size() != 0) begin
        e2 = exp_q2.pop_front();
        check("rx2_word", 32'({ferr2, perr2, rx_data2}), 32'(e2));
      end
    end
  end

  // ------------------------------------------------------------ reference model
  function automatic logic ref_par(input logic [7:0] d, input int mode);
    return (mode == 1) ? ^d : ~^d;
  endfunction

  // Line bits of one frame, bit 0 first: start, data LSB first, parity, stops
  function automatic logic [15:0] model_frame(input logic [7:0] d, input int pm,
                                              input int ns, output int n);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    n = 9;
    if (pm != 0) begin
      b[9] = ref_par(d, pm);
      n = 10;
    end
    n = n + ns;
    return b;
  endfunction

  // ------------------------------------------------------------ driver tasks
  task automatic set_tx(input int p, input logic v, input logic [7:0] d);
    if (p == 0) begin tx_valid0 = v; tx_data0 = d; end
    else        begin tx_valid1 = v; tx_data1 = d; end
  endtask

  task automatic set_rx(input int p, input logic v);
    if (p == 0) rx_in0 = v;
    else        rx_in2 = v;
  endtask

  function automatic logic get_txo(input int p);
    return (p == 0) ? tx_out0 : tx_out1;
  endfunction

  function automatic logic get_rdy(input int p);
    return (p == 0) ? tx_ready0 : tx_ready1;
  endfunction

  task automatic drive_bits(input int p, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(p, b[i]);
      repeat (BITC) @(negedge clk);
    end
  endtask

  // Follows the line for ncyc cycles after acceptance; one comparison per bit
  task automatic tx_watch(input int p, input logic [15:0] b, input int ncyc,
                          input logic keep_valid, input logic [7:0] next_d);
    int wrong;
    wrong = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) set_tx(p, keep_valid, next_d);
      if (get_txo(p) !== b[(k-1)/BITC] || get_rdy(p) !== 1'b0) wrong++;
      if ((k % BITC) == 0 || k == ncyc) begin
        check($sformatf("tx%0d_bit%0d_wrong_cycles", p, (k-1)/BITC), 32'(wrong), 32'd0);
        wrong = 0;
      end
    end
  endtask

  task automatic tx_frame(input int p, input logic [7:0] d, input logic [15:0] b, input int n);
    check($sformatf("tx%0d_ready_before", p), 32'(get_rdy(p)), 32'd1);
    set_tx(p, 1'b1, d);
    tx_watch(p, b, n * BITC, 1'b0, 8'h00);
    @(negedge clk);
    check($sformatf("tx%0d_ready_after", p), 32'(get_rdy(p)), 32'd1);
    check($sformatf("tx%0d_idle_line", p), 32'(get_txo(p)), 32'd1);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    int          port;
    logic [7:0]  data;
    logic [15:0] bits;
    int          n;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[7];

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] fb;
    logic        pb, sb;
    int          n;

    reset = 1'b0;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    tx_valid2 = 1'b0; tx_data2 = 8'h00;
    rx_in0 = 1'b1; rx_in2 = 1'b1;

    tx_tab[0] = '{0, 8'hA5, 16'h034A, 10};
    tx_tab[1] = '{1, 8'h3C, 16'h0478, 11};
    tx_tab[2] = '{1, 8'hFF, 16'h05FE, 11};
    tx_tab[3] = '{0, 8'h00, 16'h0200, 10};

    rx_tab[0] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    rx_tab[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    rx_tab[2] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    rx_tab[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    rx_tab[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    rx_tab[5] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
    rx_tab[6] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_out", 32'(tx_out0), 32'd1);
    check("rst_tx_ready", 32'(tx_ready0), 32'd1);
    check("rst_rx_valid", 32'(rx_valid0), 32'd0);
    check("rst_rx_data", 32'(rx_data0), 32'd0);
    check("rst_rx_flags", 32'({perr0, ferr0}), 32'd0);
    check("rst_tx_out_u1", 32'(tx_out1), 32'd1);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // TX vectors with hand-derived line patterns (u1 also loops back to RX)
    for (int i = 0; i < 4; i++) begin
      if (tx_tab[i].port == 1) exp_q1.push_back({2'b00, tx_tab[i].data});
      tx_frame(tx_tab[i].port, tx_tab[i].data, tx_tab[i].bits, tx_tab[i].n);
      repeat (8) @(negedge clk);
    end

    // Odd-parity, two-stop receiver vectors with forced parity/stop bits
    for (int i = 0; i < 7; i++) begin
      exp_q2.push_back({rx_tab[i].exp_ferr, rx_tab[i].exp_perr, rx_tab[i].exp_data});
      drive_bits(2, {4'hF, 1'b1, rx_tab[i].stop, rx_tab[i].par, rx_tab[i].data, 1'b0}, 12);
      set_rx(2, 1'b1);
      repeat (BITC) @(negedge clk);
    end

    // Start-bit glitch of 3 ticks must be rejected, then 0x55 received
    set_rx(0, 1'b0);
    repeat (12) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2 * BITC) @(negedge clk);
    check("glitch_no_strobe_pending", 32'(exp_q0.size()), 32'd0);
    exp_q0.push_back({2'b00, 8'h55});
    drive_bits(0, {6'h3F, 1'b1, 8'h55, 1'b0}, 10);
    set_rx(0, 1'b1);
    repeat (BITC) @(negedge clk);

    // Break: 0x81 with low stop, line held low 5 more bit times, one strobe only
    exp_q0.push_back({1'b1, 1'b0, 8'h81});
    drive_bits(0, {7'h00, 8'h81, 1'b0}, 10);
    repeat (5 * BITC) @(negedge clk);
    check("break_single_strobe", 32'(exp_q0.size()), 32'd0);
    set_rx(0, 1'b1);
    repeat (2 * BITC) @(negedge clk);
    exp_q0.push_back({2'b00, 8'h7E});
    drive_bits(0, {6'h3F, 1'b1, 8'h7E, 1'b0}, 10);
    set_rx(0, 1'b1);
    repeat (BITC) @(negedge clk);

    // Random 8N1 receive with occasional low stop bit
    for (int i = 0; i < 5; i++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      fb = model_frame(d, 0, 1, n);
      fb[9] = sb;
      exp_q0.push_back({!sb, 1'b0, d});
      drive_bits(0, fb, n);
      set_rx(0, 1'b1);
      repeat ($urandom_range(BITC, 3 * BITC)) @(negedge clk);
    end

    // Random even-parity loopback: line pattern and received word
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      fb = model_frame(d, 1, 1, n);
      exp_q1.push_back({2'b00, d});
      tx_frame(1, d, fb, n);
    end

    // Random odd-parity, two-stop receive with random parity/stop bits
    for (int i = 0; i < 4; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 2) != 0);
      fb = model_frame(d, 2, 2, n);
      fb[9]  = pb;
      fb[10] = sb;
      exp_q2.push_back({!sb, pb != ref_par(d, 2), d});
      drive_bits(2, fb, n);
      set_rx(2, 1'b1);
      repeat (BITC) @(negedge clk);
    end
    repeat (2 * BITC) @(negedge clk);

    // Back-to-back frames with tx_valid held, then reset mid-frame
    set_tx(0, 1'b1, 8'h11);
    tx_watch(0, 16'h0222, 10 * BITC, 1'b1, 8'h22);
    @(negedge clk);
    check("b2b_ready_one_cycle", 32'(tx_ready0), 32'd1);
    check("b2b_line_high", 32'(tx_out0), 32'd1);
    tx_watch(0, 16'h0244, 3 * BITC + 32, 1'b0, 8'h00);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_tx_out", 32'(tx_out0), 32'd1);
    check("midreset_tx_ready", 32'(tx_ready0), 32'd1);
    check("midreset_rx_data", 32'(rx_data0), 32'd0);
    check("midreset_rx_valid", 32'(rx_valid0), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tx_frame(0, 8'h33, 16'h0266, 10);

    repeat (3 * BITC) @(negedge clk);
    check("rx0_all_received", 32'(exp_q0.size()), 32'd0);
    check("rx1_all_received", 32'(exp_q1.size()), 32'd0);
    check("rx2_all_received", 32'(exp_q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
